// File: rtl/avmm_pio_ext.sv
// Avalon-MM parallel I/O slave: debounced inputs with edge capture and maskable irq,
// plus an output register with atomic set/clear aliases.
module avmm_pio_ext #(
  parameter int unsigned     IN_W         = 2,
  parameter int unsigned     OUT_W        = 8,
  parameter int unsigned     DEBOUNCE_CYC = 50000,
  parameter logic [OUT_W-1:0] OUT_RESET   = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       avs_address,
  input  logic             avs_read,
  input  logic             avs_write,
  input  logic [31:0]      avs_writedata,
  output logic [31:0]      avs_readdata,
  output logic             irq,
  input  logic [IN_W-1:0]  pio_in,
  output logic [OUT_W-1:0] pio_out
);

  localparam int unsigned      CNT_W   = $clog2(DEBOUNCE_CYC) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYC - 1);

  logic [IN_W-1:0]  sync1_q, sync2_q;
  logic [IN_W-1:0]  stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q [IN_W];
  logic [CNT_W-1:0] cnt_d [IN_W];
  logic [OUT_W-1:0] out_q, out_d;
  logic [IN_W-1:0]  irq_mask_q, irq_mask_d;
  logic [IN_W-1:0]  edge_cap_q, edge_cap_d;
  logic [1:0]       edge_cfg_q, edge_cfg_d;
  logic [31:0]      readdata_q, readdata_d;
  logic [31:0]      rdata;
  logic [IN_W-1:0]  rise, fall, evt;

  // Only the low bits of writedata are meaningful for any register.
  logic unused_wd;
  assign unused_wd = ^avs_writedata;

  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < int'(IN_W); i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          stable_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  assign rise = stable_d & ~stable_q;
  assign fall = ~stable_d & stable_q;

  always_comb begin
    evt = '0;
    case (edge_cfg_q)
      2'b00:   evt = rise;
      2'b01:   evt = fall;
      2'b10:   evt = rise | fall;
      default: evt = '0;
    endcase
  end

  always_comb begin
    out_d      = out_q;
    irq_mask_d = irq_mask_q;
    edge_cap_d = edge_cap_q;
    edge_cfg_d = edge_cfg_q;
    if (avs_write) begin
      case (avs_address)
        3'd1:    out_d      = avs_writedata[OUT_W-1:0];
        3'd2:    out_d      = out_q | avs_writedata[OUT_W-1:0];
        3'd3:    out_d      = out_q & ~avs_writedata[OUT_W-1:0];
        3'd4:    irq_mask_d = avs_writedata[IN_W-1:0];
        3'd5:    edge_cap_d = edge_cap_q & ~avs_writedata[IN_W-1:0];
        3'd6:    edge_cfg_d = avs_writedata[1:0];
        default: ;
      endcase
    end
    // A new event overrides a simultaneous write-1-to-clear.
    edge_cap_d = edge_cap_d | evt;
  end

  always_comb begin
    rdata = '0;
    case (avs_address)
      3'd0:    rdata[IN_W-1:0]  = stable_q;
      3'd1:    rdata[OUT_W-1:0] = out_q;
      3'd4:    rdata[IN_W-1:0]  = irq_mask_q;
      3'd5:    rdata[IN_W-1:0]  = edge_cap_q;
      3'd6:    rdata[1:0]       = edge_cfg_q;
      default: rdata = '0;
    endcase
    readdata_d = avs_read ? rdata : readdata_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      stable_q   <= '0;
      cnt_q      <= '{default: '0};
      out_q      <= OUT_RESET;
      irq_mask_q <= '0;
      edge_cap_q <= '0;
      edge_cfg_q <= '0;
      readdata_q <= '0;
    end else begin
      sync1_q    <= pio_in;
      sync2_q    <= sync1_q;
      stable_q   <= stable_d;
      cnt_q      <= cnt_d;
      out_q      <= out_d;
      irq_mask_q <= irq_mask_d;
      edge_cap_q <= edge_cap_d;
      edge_cfg_q <= edge_cfg_d;
      readdata_q <= readdata_d;
    end
  end

  assign avs_readdata = readdata_q;
  assign pio_out      = out_q;
  assign irq          = |(edge_cap_q & irq_mask_q);

endmodule

// File: tb/tb_avmm_pio_ext.sv
// Directed bench for avmm_pio_ext with DEBOUNCE_CYC=4, IN_W=2, OUT_W=8.
module tb_avmm_pio_ext;

  logic        clk;
  logic        reset_n;
  logic [2:0]  avs_address;
  logic        avs_read;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic [31:0] avs_readdata;
  logic        irq;
  logic [1:0]  pio_in;
  logic [7:0]  pio_out;

  int checks = 0;
  int errors = 0;

  avmm_pio_ext #(
    .IN_W        (2),
    .OUT_W       (8),
    .DEBOUNCE_CYC(4),
    .OUT_RESET   (8'h00)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .avs_address  (avs_address),
    .avs_read     (avs_read),
    .avs_write    (avs_write),
    .avs_writedata(avs_writedata),
    .avs_readdata (avs_readdata),
    .irq          (irq),
    .pio_in       (pio_in),
    .pio_out      (pio_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus_write(input logic [2:0] addr, input logic [31:0] data);
    avs_address   = addr;
    avs_writedata = data;
    avs_write     = 1'b1;
    tick(1);
    avs_write     = 1'b0;
  endtask

  task automatic bus_read(input logic [2:0] addr, output logic [31:0] data);
    avs_address = addr;
    avs_read    = 1'b1;
    tick(1);
    avs_read    = 1'b0;
    data        = avs_readdata;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] rd;
    reset_n       = 1'b0;
    avs_address   = '0;
    avs_read      = 1'b0;
    avs_write     = 1'b0;
    avs_writedata = '0;
    pio_in        = 2'b00;
    tick(2);
    check("rst_pio_out", 32'(pio_out), 32'h00);
    check("rst_irq", 32'(irq), 32'h0);
    check("rst_readdata", avs_readdata, 32'h0);
    reset_n = 1'b1;
    tick(1);

    // Basic read and output register aliases
    bus_read(3'd0, rd);
    check("data_after_reset", rd, 32'h0);
    bus_write(3'd1, 32'h0000_00A5);
    check("out_write", 32'(pio_out), 32'hA5);
    bus_write(3'd2, 32'hFFFF_FF0F);
    check("out_set", 32'(pio_out), 32'hAF);
    bus_write(3'd3, 32'h0000_0081);
    check("out_clr", 32'(pio_out), 32'h2E);
    bus_read(3'd1, rd);
    check("read_out", rd, 32'h2E);
    bus_read(3'd2, rd);
    check("read_out_set", rd, 32'h0);
    bus_read(3'd3, rd);
    check("read_out_clr", rd, 32'h0);

    // Simultaneous read+write returns the pre-write value
    bus_read(3'd1, rd);
    avs_address   = 3'd1;
    avs_writedata = 32'h55;
    avs_read      = 1'b1;
    avs_write     = 1'b1;
    tick(1);
    avs_read  = 1'b0;
    avs_write = 1'b0;
    check("rw_same_cycle_read", avs_readdata, 32'h2E);
    check("rw_same_cycle_write", 32'(pio_out), 32'h55);
    bus_write(3'd0, 32'hFFFF_FFFF);
    check("readdata_hold", avs_readdata, 32'h2E);
    bus_write(3'd4, 32'hFFFF_FFFF);
    bus_read(3'd4, rd);
    check("irq_mask_width", rd, 32'h3);
    bus_write(3'd4, 32'h0);
    bus_read(3'd7, rd);
    check("reserved_read", rd, 32'h0);

    // Short glitch is filtered out
    pio_in = 2'b01;
    tick(3);
    pio_in = 2'b00;
    tick(6);
    bus_read(3'd0, rd);
    check("glitch_data", rd, 32'h0);
    bus_read(3'd5, rd);
    check("glitch_cap", rd, 32'h0);

    // Rising capture with irq, exact 6-cycle latency
    bus_write(3'd4, 32'h1);
    pio_in = 2'b01;
    tick(5);
    check("irq_before_stable", 32'(irq), 32'h0);
    avs_address = 3'd0;
    avs_read    = 1'b1;
    tick(1);
    avs_read = 1'b0;
    check("data_at_edge6_pre", avs_readdata, 32'h0);
    check("irq_at_edge6", 32'(irq), 32'h1);
    bus_read(3'd0, rd);
    check("data_after_edge6", rd, 32'h1);
    bus_read(3'd5, rd);
    check("cap_rise", rd, 32'h1);
    bus_write(3'd5, 32'h1);
    check("irq_after_w1c", 32'(irq), 32'h0);
    bus_read(3'd5, rd);
    check("cap_after_w1c", rd, 32'h0);
    pio_in = 2'b00;
    tick(8);
    bus_read(3'd5, rd);
    check("cap_fall_ignored", rd, 32'h0);
    check("irq_fall_ignored", 32'(irq), 32'h0);

    // Both-edge mode on channel 1, masked
    bus_write(3'd6, 32'hFFFF_FFFE);
    bus_read(3'd6, rd);
    check("edge_cfg_read", rd, 32'h2);
    bus_write(3'd4, 32'h0);
    pio_in = 2'b10;
    tick(8);
    bus_read(3'd5, rd);
    check("both_rise_cap", rd, 32'h2);
    bus_write(3'd5, 32'h2);
    pio_in = 2'b00;
    tick(8);
    bus_read(3'd5, rd);
    check("both_fall_cap", rd, 32'h2);
    check("irq_masked", 32'(irq), 32'h0);
    bus_write(3'd4, 32'h2);
    check("irq_unmasked", 32'(irq), 32'h1);

    // W1C colliding with a new rising event: set wins
    bus_write(3'd6, 32'h0);
    bus_write(3'd5, 32'h3);
    check("irq_cleared", 32'(irq), 32'h0);
    pio_in = 2'b01;
    tick(5);
    bus_write(3'd5, 32'h1);
    bus_read(3'd5, rd);
    check("set_beats_w1c", rd, 32'h1);

    // Asynchronous reset mid-debounce
    pio_in = 2'b00;
    tick(3);
    #3;
    reset_n = 1'b0;
    #1;
    check("async_rst_pio_out", 32'(pio_out), 32'h00);
    check("async_rst_cap", 32'(dut.edge_cap_q), 32'h0);
    check("async_rst_readdata", avs_readdata, 32'h0);
    tick(1);
    reset_n = 1'b1;
    tick(1);
    bus_read(3'd0, rd);
    check("post_rst_data", rd, 32'h0);
    bus_read(3'd5, rd);
    check("post_rst_cap", rd, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
